// File: rtl/io_unit_if.sv
// Bundle of CPU-side and peripheral-side signals of io_unit.
// The slave modport is the io_unit view; the master modport is the CPU/peripheral view.
interface io_unit_if #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 4
);
  localparam int IDW = $clog2(NPORTS);

  logic [WIDTH-1:0]        data_mem;
  logic [WIDTH-1:0]        data_reg;
  logic                    sel_src;
  logic                    wr;
  logic [IDW-1:0]          id_out;
  logic                    rd;
  logic [IDW-1:0]          id_in;
  logic [WIDTH-1:0]        data_in;
  logic                    data_in_vld;
  logic [NPORTS*WIDTH-1:0] in_bus;
  logic [NPORTS-1:0]       in_valid;
  logic [NPORTS-1:0]       in_ready;
  logic [NPORTS*WIDTH-1:0] out_bus;
  logic [NPORTS-1:0]       out_valid;
  logic [NPORTS-1:0]       out_ack;
  logic [NPORTS-1:0]       irq_mask;
  logic                    clr_err;
  logic [NPORTS-1:0]       ovr_err;
  logic                    rd_err;
  logic                    irq;

  modport master (
    output data_mem, data_reg, sel_src, wr, id_out, rd, id_in,
    output in_bus, in_valid, out_ack, irq_mask, clr_err,
    input  data_in, data_in_vld, in_ready, out_bus, out_valid,
    input  ovr_err, rd_err, irq
  );

  modport slave (
    input  data_mem, data_reg, sel_src, wr, id_out, rd, id_in,
    input  in_bus, in_valid, out_ack, irq_mask, clr_err,
    output data_in, data_in_vld, in_ready, out_bus, out_valid,
    output ovr_err, rd_err, irq
  );
endinterface

// File: rtl/io_unit.sv
// Parametrised CPU I/O unit: NPORTS output registers and NPORTS input holding
// registers with valid/ready handshakes, sticky overrun/read errors and a level irq.
module io_unit #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 4
) (
  input logic      clk,
  input logic      reset,
  io_unit_if.slave bus
);
  localparam int IDW = $clog2(NPORTS);

  logic [WIDTH-1:0]        wdata;
  logic [NPORTS*WIDTH-1:0] out_q;
  logic [NPORTS-1:0]       out_vld_q;
  logic [WIDTH-1:0]        hold_q [NPORTS];
  logic [NPORTS-1:0]       in_full_q;
  logic [NPORTS-1:0]       ovr_q;
  logic                    rd_err_q;

  assign wdata = bus.sel_src ? bus.data_reg : bus.data_mem;

  // Error clears are issued first so that a same-cycle error event, assigned later, wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_vld_q <= '0;
      in_full_q <= '0;
      ovr_q     <= '0;
      rd_err_q  <= 1'b0;
      for (int i = 0; i < NPORTS; i++) hold_q[i] <= '0;
    end else begin
      if (bus.clr_err) begin
        ovr_q    <= '0;
        rd_err_q <= 1'b0;
      end
      for (int i = 0; i < NPORTS; i++) begin
        if (bus.wr && bus.id_out == IDW'(i)) begin
          out_q[i*WIDTH +: WIDTH] <= wdata;
          out_vld_q[i]            <= 1'b1;
          if (out_vld_q[i] && !bus.out_ack[i]) ovr_q[i] <= 1'b1;
        end else if (bus.out_ack[i]) begin
          out_vld_q[i] <= 1'b0;
        end
        // A full port only drains; it cannot accept an offer in the same cycle.
        if (in_full_q[i]) begin
          if (bus.rd && bus.id_in == IDW'(i)) in_full_q[i] <= 1'b0;
        end else if (bus.in_valid[i]) begin
          hold_q[i]    <= bus.in_bus[i*WIDTH +: WIDTH];
          in_full_q[i] <= 1'b1;
        end
      end
      if (bus.rd && !in_full_q[bus.id_in]) rd_err_q <= 1'b1;
    end
  end

  assign bus.out_bus     = out_q;
  assign bus.out_valid   = out_vld_q;
  assign bus.data_in     = hold_q[bus.id_in];
  assign bus.data_in_vld = in_full_q[bus.id_in];
  assign bus.in_ready    = ~in_full_q;
  assign bus.ovr_err     = ovr_q;
  assign bus.rd_err      = rd_err_q;
  assign bus.irq         = |(in_full_q & bus.irq_mask);
endmodule

// File: tb/tb_io_unit.sv
// Self-checking bench for io_unit: directed scenarios on a 4x8 and an 8x16 instance,
// plus randomized traffic on the 4x8 instance checked against a transaction-level model.
module tb_io_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  io_unit_if #(.WIDTH(8),  .NPORTS(4)) bus4 ();
  io_unit_if #(.WIDTH(16), .NPORTS(8)) bus8 ();

  io_unit #(.WIDTH(8),  .NPORTS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  io_unit #(.WIDTH(16), .NPORTS(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  // Reference state for the 4x8 instance, kept as per-port words and flags.
  logic [7:0] m_out  [4];
  logic [7:0] m_hold [4];
  logic [3:0] m_vld, m_full, m_ovr;
  logic       m_rderr;

  task automatic idle();
    bus4.data_mem = '0; bus4.data_reg = '0; bus4.sel_src = 0; bus4.wr = 0; bus4.id_out = '0;
    bus4.rd = 0; bus4.id_in = '0; bus4.in_bus = '0; bus4.in_valid = '0; bus4.out_ack = '0;
    bus4.irq_mask = '0; bus4.clr_err = 0;
    bus8.data_mem = '0; bus8.data_reg = '0; bus8.sel_src = 0; bus8.wr = 0; bus8.id_out = '0;
    bus8.rd = 0; bus8.id_in = '0; bus8.in_bus = '0; bus8.in_valid = '0; bus8.out_ack = '0;
    bus8.irq_mask = '0; bus8.clr_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_out[p]  = '0;
      m_hold[p] = '0;
    end
    m_vld = '0; m_full = '0; m_ovr = '0; m_rderr = 0;
  endtask

  // Applies one clock edge worth of the block's rules to the model, using current inputs.
  task automatic model_edge();
    logic [3:0] old_full, old_vld;
    old_full = m_full;
    old_vld  = m_vld;
    if (bus4.clr_err) begin
      m_ovr   = '0;
      m_rderr = 0;
    end
    for (int p = 0; p < 4; p++) if (bus4.out_ack[p]) m_vld[p] = 0;
    if (bus4.wr) begin
      if (old_vld[bus4.id_out] && !bus4.out_ack[bus4.id_out]) m_ovr[bus4.id_out] = 1;
      m_out[bus4.id_out] = bus4.sel_src ? bus4.data_reg : bus4.data_mem;
      m_vld[bus4.id_out] = 1;
    end
    if (bus4.rd) begin
      if (old_full[bus4.id_in]) m_full[bus4.id_in] = 0;
      else m_rderr = 1;
    end
    for (int p = 0; p < 4; p++) begin
      if (!old_full[p] && bus4.in_valid[p]) begin
        m_hold[p] = bus4.in_bus[p*8 +: 8];
        m_full[p] = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    bus4.irq_mask = '1;
    bus8.irq_mask = '1;
    repeat (2) tick();
    n_tests++; if (bus4.out_bus !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_out_bus: got %h want 0", bus4.out_bus); end
    n_tests++; if (bus4.out_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b want 0000", bus4.out_valid); end
    n_tests++; if (bus4.in_ready !== 4'hF) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b want 1111", bus4.in_ready); end
    n_tests++; if ({bus4.ovr_err, bus4.rd_err, bus4.irq, bus4.data_in_vld} !== 7'h0) begin n_fail++; $display("[TB] FAIL rst_flags: got %b want 0", {bus4.ovr_err, bus4.rd_err, bus4.irq, bus4.data_in_vld}); end
    n_tests++; if (bus8.in_ready !== 8'hFF || bus8.out_valid !== 8'h0) begin n_fail++; $display("[TB] FAIL rst8: ready %b valid %b want ff/00", bus8.in_ready, bus8.out_valid); end
    reset = 0;
    idle();
    tick();
  endtask

  task automatic test_output_write();
    bus4.wr = 1; bus4.id_out = 2; bus4.sel_src = 1; bus4.data_reg = 8'hA5; bus4.data_mem = 8'h5A;
    tick();
    bus4.wr = 0;
    n_tests++; if (bus4.out_bus !== 32'h00A5_0000) begin n_fail++; $display("[TB] FAIL wr_bus: got %h want 00a50000", bus4.out_bus); end
    n_tests++; if (bus4.out_valid !== 4'b0100) begin n_fail++; $display("[TB] FAIL wr_valid: got %b want 0100", bus4.out_valid); end
    bus4.wr = 1; bus4.sel_src = 0; bus4.data_mem = 8'h3C;
    tick();
    bus4.wr = 0;
    n_tests++; if (bus4.out_bus !== 32'h003C_0000) begin n_fail++; $display("[TB] FAIL ovr_bus: got %h want 003c0000", bus4.out_bus); end
    n_tests++; if (bus4.ovr_err !== 4'b0100) begin n_fail++; $display("[TB] FAIL ovr_set: got %b want 0100", bus4.ovr_err); end
    bus4.clr_err = 1;
    tick();
    bus4.clr_err = 0;
    n_tests++; if (bus4.ovr_err !== 4'b0000) begin n_fail++; $display("[TB] FAIL ovr_clr: got %b want 0000", bus4.ovr_err); end
    bus4.wr = 1; bus4.data_mem = 8'hC3; bus4.out_ack = 4'b0100;
    tick();
    bus4.wr = 0; bus4.out_ack = '0;
    n_tests++; if (bus4.ovr_err !== 4'b0000 || bus4.out_valid !== 4'b0100) begin n_fail++; $display("[TB] FAIL wr_ack: ovr %b valid %b want 0000/0100", bus4.ovr_err, bus4.out_valid); end
    n_tests++; if (bus4.out_bus !== 32'h00C3_0000) begin n_fail++; $display("[TB] FAIL wr_ack_bus: got %h want 00c30000", bus4.out_bus); end
    bus4.out_ack = 4'b0100;
    tick();
    bus4.out_ack = 4'hF;
    n_tests++; if (bus4.out_valid !== 4'b0000 || bus4.out_bus !== 32'h00C3_0000) begin n_fail++; $display("[TB] FAIL ack: valid %b bus %h want 0000/00c30000", bus4.out_valid, bus4.out_bus); end
    tick();
    bus4.out_ack = '0;
    n_tests++; if (bus4.out_valid !== 4'b0000 || bus4.ovr_err !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_ack: valid %b ovr %b want 0", bus4.out_valid, bus4.ovr_err); end
  endtask

  task automatic test_back_to_back();
    bus4.out_ack = 4'b0001; bus4.sel_src = 1; bus4.id_out = 0;
    for (int k = 0; k < 4; k++) begin
      bus4.wr = 1; bus4.data_reg = 8'(8'h10 + k);
      tick();
      n_tests++; if (bus4.out_bus[7:0] !== 8'(8'h10 + k) || bus4.out_valid[0] !== 1'b1 || bus4.ovr_err[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_%0d: word %h vld %b ovr %b want %h/1/0", k, bus4.out_bus[7:0], bus4.out_valid[0], bus4.ovr_err[0], 8'(8'h10 + k)); end
    end
    bus4.wr = 0;
    tick();
    bus4.out_ack = '0;
    n_tests++; if (bus4.out_valid[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_drain: got %b want 0", bus4.out_valid[0]); end
  endtask

  task automatic test_input();
    bus4.id_in = 1; bus4.irq_mask = 4'b0010; bus4.in_bus = 32'h0000_7700; bus4.in_valid = 4'b0010;
    #1;
    n_tests++; if (bus4.in_ready !== 4'hF || bus4.irq !== 1'b0) begin n_fail++; $display("[TB] FAIL in_pre: ready %b irq %b want 1111/0", bus4.in_ready, bus4.irq); end
    tick();
    n_tests++; if (bus4.in_ready !== 4'b1101 || bus4.data_in !== 8'h77 || bus4.data_in_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL in_cap: ready %b data %h vld %b want 1101/77/1", bus4.in_ready, bus4.data_in, bus4.data_in_vld); end
    n_tests++; if (bus4.irq !== 1'b1) begin n_fail++; $display("[TB] FAIL in_irq: got %b want 1", bus4.irq); end
    bus4.in_bus = 32'h0000_1100;
    tick();
    n_tests++; if (bus4.data_in !== 8'h77 || bus4.in_ready[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL in_hold: data %h ready %b want 77/0", bus4.data_in, bus4.in_ready[1]); end
    bus4.rd = 1;
    #1;
    n_tests++; if (bus4.data_in !== 8'h77 || bus4.data_in_vld !== 1'b1 || bus4.in_ready[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL pop_same: data %h vld %b ready %b want 77/1/0", bus4.data_in, bus4.data_in_vld, bus4.in_ready[1]); end
    tick();
    bus4.rd = 0;
    n_tests++; if (bus4.in_ready[1] !== 1'b1 || bus4.data_in_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL pop: ready %b vld %b want 1/0", bus4.in_ready[1], bus4.data_in_vld); end
    tick();
    n_tests++; if (bus4.data_in !== 8'h11 || bus4.data_in_vld !== 1'b1 || bus4.irq !== 1'b1) begin n_fail++; $display("[TB] FAIL refill: data %h vld %b irq %b want 11/1/1", bus4.data_in, bus4.data_in_vld, bus4.irq); end
    bus4.in_valid = '0; bus4.rd = 1;
    tick();
    bus4.rd = 0;
    n_tests++; if (bus4.in_ready !== 4'hF || bus4.rd_err !== 1'b0 || bus4.irq !== 1'b0) begin n_fail++; $display("[TB] FAIL drain: ready %b rd_err %b irq %b want 1111/0/0", bus4.in_ready, bus4.rd_err, bus4.irq); end
  endtask

  task automatic test_rd_err();
    bus4.id_in = 3; bus4.rd = 1;
    tick();
    n_tests++; if (bus4.rd_err !== 1'b1 || bus4.in_ready !== 4'hF) begin n_fail++; $display("[TB] FAIL rd_err_set: err %b ready %b want 1/1111", bus4.rd_err, bus4.in_ready); end
    bus4.clr_err = 1;
    tick();
    n_tests++; if (bus4.rd_err !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_err_clr_race: got %b want 1", bus4.rd_err); end
    bus4.rd = 0;
    tick();
    bus4.clr_err = 0;
    n_tests++; if (bus4.rd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_err_clr: got %b want 0", bus4.rd_err); end
  endtask

  task automatic test_async_reset();
    bus4.wr = 1; bus4.id_out = 0; bus4.sel_src = 0; bus4.data_mem = 8'h9E;
    bus4.in_valid = 4'b1000; bus4.in_bus = 32'hD200_0000; bus4.irq_mask = 4'hF; bus4.id_in = 3;
    bus8.wr = 1; bus8.id_out = 7; bus8.sel_src = 1; bus8.data_reg = 16'hBEEF;
    bus8.in_valid = 8'h20; bus8.in_bus[5*16 +: 16] = 16'h1234; bus8.irq_mask = 8'hFF; bus8.id_in = 5;
    tick();
    idle();
    bus4.irq_mask = 4'hF; bus4.id_in = 3;
    bus8.irq_mask = 8'hFF; bus8.id_in = 5;
    #1;
    n_tests++; if (bus4.out_valid !== 4'b0001 || bus4.in_ready !== 4'b0111 || bus4.data_in !== 8'hD2) begin n_fail++; $display("[TB] FAIL pre_rst4: valid %b ready %b data %h want 0001/0111/d2", bus4.out_valid, bus4.in_ready, bus4.data_in); end
    n_tests++; if (bus8.out_bus[127:112] !== 16'hBEEF || bus8.out_valid !== 8'h80 || bus8.in_ready !== 8'hDF || bus8.data_in !== 16'h1234) begin n_fail++; $display("[TB] FAIL pre_rst8: word %h valid %b ready %b data %h", bus8.out_bus[127:112], bus8.out_valid, bus8.in_ready, bus8.data_in); end
    #1;
    reset = 1;
    #1;
    n_tests++; if (bus4.out_bus !== 32'h0 || bus4.out_valid !== 4'h0 || bus4.in_ready !== 4'hF || bus4.irq !== 1'b0 || bus4.data_in !== 8'h0) begin n_fail++; $display("[TB] FAIL async4: bus %h valid %b ready %b irq %b data %h", bus4.out_bus, bus4.out_valid, bus4.in_ready, bus4.irq, bus4.data_in); end
    n_tests++; if (bus8.out_bus !== 128'h0 || bus8.out_valid !== 8'h0 || bus8.in_ready !== 8'hFF || bus8.irq !== 1'b0 || bus8.data_in !== 16'h0 || bus8.data_in_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL async8: valid %b ready %b irq %b data %h", bus8.out_valid, bus8.in_ready, bus8.irq, bus8.data_in); end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_bus;
    idle();
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      bus4.wr       = ($urandom_range(0, 2) == 0);
      bus4.id_out   = 2'($urandom_range(0, 3));
      bus4.sel_src  = 1'($urandom);
      bus4.data_mem = 8'($urandom);
      bus4.data_reg = 8'($urandom);
      bus4.rd       = ($urandom_range(0, 2) == 0);
      bus4.id_in    = 2'($urandom_range(0, 3));
      bus4.in_bus   = $urandom;
      bus4.in_valid = 4'($urandom);
      bus4.out_ack  = 4'($urandom);
      bus4.irq_mask = 4'($urandom);
      bus4.clr_err  = ($urandom_range(0, 9) == 0);
      #1;
      n_tests++; if (bus4.data_in !== m_hold[bus4.id_in] || bus4.data_in_vld !== m_full[bus4.id_in]) begin n_fail++; $display("[TB] FAIL rnd_data_in c%0d: got %h/%b want %h/%b", c, bus4.data_in, bus4.data_in_vld, m_hold[bus4.id_in], m_full[bus4.id_in]); end
      n_tests++; if (bus4.in_ready !== ~m_full || bus4.irq !== |(m_full & bus4.irq_mask)) begin n_fail++; $display("[TB] FAIL rnd_ready c%0d: got %b/%b want %b/%b", c, bus4.in_ready, bus4.irq, ~m_full, |(m_full & bus4.irq_mask)); end
      model_edge();
      tick();
      exp_bus = {m_out[3], m_out[2], m_out[1], m_out[0]};
      n_tests++; if (bus4.out_bus !== exp_bus || bus4.out_valid !== m_vld) begin n_fail++; $display("[TB] FAIL rnd_out c%0d: got %h/%b want %h/%b", c, bus4.out_bus, bus4.out_valid, exp_bus, m_vld); end
      n_tests++; if (bus4.ovr_err !== m_ovr || bus4.rd_err !== m_rderr) begin n_fail++; $display("[TB] FAIL rnd_err c%0d: got %b/%b want %b/%b", c, bus4.ovr_err, bus4.rd_err, m_ovr, m_rderr); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_output_write();
    test_back_to_back();
    test_input();
    test_rd_err();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
